// File: rtl/pre_hash_pe_dispatcher_pkg.sv
// Shared sizing for the hash-PE scatter stage.
// Derived log2 widths and the dispatcher state type.
package pre_hash_pe_dispatcher_pkg;

    localparam int HASH_ISSUE_WIDTH      = 8;
    localparam int NUM_HASH_PE           = 8;
    localparam int ADDR_WIDTH            = 16;
    localparam int HASH_BITS             = 8;
    localparam int NUM_HASH_PE_LOG2      = $clog2(NUM_HASH_PE);
    localparam int HASH_ISSUE_WIDTH_LOG2 = $clog2(HASH_ISSUE_WIDTH);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DISPATCH = 1'b1
    } disp_state_t;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/pre_hash_pe_dispatcher_bank_priority_grant.sv
// Per-bank arbiter: picks the lowest-index pending position
// whose bank id matches this PE.
module bank_priority_grant
    import pre_hash_pe_dispatcher_pkg::*;
#(
    parameter int ISSUE_W = HASH_ISSUE_WIDTH,
    parameter int NUM_PE  = NUM_HASH_PE,
    parameter int PE_ID   = 0,
    localparam int PL     = clog2_min1(NUM_PE),
    localparam int IL     = clog2_min1(ISSUE_W)
) (
    input  logic [ISSUE_W-1:0]    i_pending,
    input  logic [ISSUE_W*PL-1:0] i_bank,
    output logic                  o_grant,
    output logic [IL-1:0]         o_idx
);

    // Scan high to low so the lowest matching index wins.
    always_comb begin
        o_grant = 1'b0;
        o_idx   = '0;
        for (int i = ISSUE_W - 1; i >= 0; i--) begin
            if (i_pending[i] && (i_bank[i*PL +: PL] == PL'(PE_ID))) begin
                o_grant = 1'b1;
                o_idx   = IL'(i);
            end
        end
    end

endmodule

// File: rtl/pre_hash_pe_dispatcher.sv
// Scatters one row of hashed byte positions onto the hash PE banks,
// serializing bank collisions over several output beats.
module pre_hash_pe_dispatcher
    import pre_hash_pe_dispatcher_pkg::*;
#(
    parameter int ISSUE_W = HASH_ISSUE_WIDTH,
    parameter int NUM_PE  = NUM_HASH_PE,
    parameter int AW      = ADDR_WIDTH,
    parameter int HW      = HASH_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 input_valid,
    input  logic [AW-1:0]        input_head_addr,
    input  logic [ISSUE_W-1:0]   input_row_mask,
    input  logic [ISSUE_W*HW-1:0] input_hash_vec,
    input  logic                 input_delim,
    input  logic [ISSUE_W*8-1:0] input_data,
    output logic                 input_ready,
    output logic                 output_valid,
    output logic [NUM_PE-1:0]    output_mask,
    output logic [NUM_PE*AW-1:0] output_addr_vec,
    output logic [NUM_PE*HW-1:0] output_hash_vec,
    output logic [NUM_PE-1:0]    output_delim_vec,
    output logic [ISSUE_W*8-1:0] output_data,
    output logic                 output_last,
    input  logic                 output_ready
);

    localparam int PL = clog2_min1(NUM_PE);
    localparam int IL = clog2_min1(ISSUE_W);

    disp_state_t          r_state;
    logic [ISSUE_W-1:0]   r_pending;
    logic [AW-1:0]        r_head;
    logic [ISSUE_W*HW-1:0] r_hash;
    logic                 r_delim;
    logic [ISSUE_W*8-1:0] r_data;

    logic                 w_busy;
    logic [ISSUE_W*PL-1:0] w_bank;
    logic [NUM_PE-1:0]    w_grant;
    logic [IL-1:0]        w_idx [NUM_PE];
    logic [ISSUE_W-1:0]   w_granted;
    logic                 w_in_hs;
    logic                 w_out_hs;

    assign w_busy = (r_state == ST_DISPATCH);

    always_comb begin
        w_bank = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_bank[i*PL +: PL] = r_hash[i*HW +: PL];
        end
    end

    for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
        bank_priority_grant #(
            .ISSUE_W (ISSUE_W),
            .NUM_PE  (NUM_PE),
            .PE_ID   (p)
        ) u_grant (
            .i_pending (r_pending),
            .i_bank    (w_bank),
            .o_grant   (w_grant[p]),
            .o_idx     (w_idx[p])
        );
    end

    // Lanes without a grant drive zero so idle lanes are deterministic.
    always_comb begin
        w_granted       = '0;
        output_addr_vec = '0;
        output_hash_vec = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            if (w_grant[p]) begin
                w_granted[w_idx[p]]       = 1'b1;
                output_addr_vec[p*AW +: AW] = r_head + AW'(w_idx[p]);
                output_hash_vec[p*HW +: HW] = r_hash[w_idx[p]*HW +: HW];
            end
        end
    end

    assign output_mask      = w_grant;
    assign output_last      = w_busy & ~|(r_pending & ~w_granted);
    assign output_delim_vec = {NUM_PE{r_delim & output_last}} & w_grant;
    assign output_valid     = w_busy;
    assign output_data      = r_data;
    assign input_ready      = ~w_busy | (output_last & output_ready);

    assign w_in_hs  = input_valid & input_ready;
    assign w_out_hs = w_busy & output_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_head    <= '0;
            r_hash    <= '0;
            r_delim   <= 1'b0;
            r_data    <= '0;
        end else if (w_in_hs) begin
            r_state   <= ST_DISPATCH;
            r_pending <= input_row_mask;
            r_head    <= input_head_addr;
            r_hash    <= input_hash_vec;
            r_delim   <= input_delim;
            r_data    <= input_data;
        end else if (w_out_hs) begin
            r_pending <= r_pending & ~w_granted;
            if (output_last) begin
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_pre_hash_pe_dispatcher.sv
// Directed bench for the hash-PE dispatcher with
// hand-computed beat patterns.
module tb_pre_hash_pe_dispatcher;

    localparam int IW = 8;
    localparam int NP = 8;
    localparam int AW = 16;
    localparam int HW = 8;

    logic            clk;
    logic            rst_n;
    logic            input_valid;
    logic [AW-1:0]   input_head_addr;
    logic [IW-1:0]   input_row_mask;
    logic [IW*HW-1:0] input_hash_vec;
    logic            input_delim;
    logic [IW*8-1:0] input_data;
    logic            input_ready;
    logic            output_valid;
    logic [NP-1:0]   output_mask;
    logic [NP*AW-1:0] output_addr_vec;
    logic [NP*HW-1:0] output_hash_vec;
    logic [NP-1:0]   output_delim_vec;
    logic [IW*8-1:0] output_data;
    logic            output_last;
    logic            output_ready;

    int n_chk;
    int n_bad;

    pre_hash_pe_dispatcher #(
        .ISSUE_W (IW),
        .NUM_PE  (NP),
        .AW      (AW),
        .HW      (HW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .input_valid      (input_valid),
        .input_head_addr  (input_head_addr),
        .input_row_mask   (input_row_mask),
        .input_hash_vec   (input_hash_vec),
        .input_delim      (input_delim),
        .input_data       (input_data),
        .input_ready      (input_ready),
        .output_valid     (output_valid),
        .output_mask      (output_mask),
        .output_addr_vec  (output_addr_vec),
        .output_hash_vec  (output_hash_vec),
        .output_delim_vec (output_delim_vec),
        .output_data      (output_data),
        .output_last      (output_last),
        .output_ready     (output_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_row(input logic [AW-1:0] head,
                             input logic [IW-1:0] mask,
                             input logic [IW*HW-1:0] hv,
                             input logic dl,
                             input logic [IW*8-1:0] data);
        input_valid     = 1'b1;
        input_head_addr = head;
        input_row_mask  = mask;
        input_hash_vec  = hv;
        input_delim     = dl;
        input_data      = data;
    endtask

    task automatic load_row(input string tag,
                            input logic [AW-1:0] head,
                            input logic [IW-1:0] mask,
                            input logic [IW*HW-1:0] hv,
                            input logic dl,
                            input logic [IW*8-1:0] data);
        check({tag, "_irdy"}, 64'(input_ready), 64'd1);
        drive_row(head, mask, hv, dl, data);
        @(posedge clk);
        @(negedge clk);
        input_valid = 1'b0;
    endtask

    // Called at a negedge; checks the beat, then advances one cycle.
    task automatic chk_beat(input string tag,
                            input logic [NP-1:0] emask,
                            input logic elast,
                            input logic [NP-1:0] edelim,
                            input logic [AW-1:0] base,
                            input int step);
        logic [AW-1:0] ea;
        check({tag, "_vld"}, 64'(output_valid), 64'd1);
        check({tag, "_mask"}, 64'(output_mask), 64'(emask));
        check({tag, "_last"}, 64'(output_last), 64'(elast));
        check({tag, "_dlm"}, 64'(output_delim_vec), 64'(edelim));
        for (int p = 0; p < NP; p++) begin
            if (emask[p]) begin
                ea = base + AW'(p * step);
                check($sformatf("%s_a%0d", tag, p),
                      64'(output_addr_vec[p*AW +: AW]), 64'(ea));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_chk           = 0;
        n_bad           = 0;
        rst_n           = 1'b0;
        input_valid     = 1'b0;
        input_head_addr = '0;
        input_row_mask  = '0;
        input_hash_vec  = '0;
        input_delim     = 1'b0;
        input_data      = '0;
        output_ready    = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_irdy", 64'(input_ready), 64'd1);
        check("rst_vld", 64'(output_valid), 64'd0);
        check("rst_mask", 64'(output_mask), 64'd0);
        check("rst_last", 64'(output_last), 64'd0);
        check("rst_addr", 64'(output_addr_vec), 64'd0);
        check("rst_data", output_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // distinct banks, one beat
        load_row("dst", 16'h0100, 8'hFF, 64'h0706050403020100, 1'b0,
                 64'h8877665544332211);
        check("dst_data", output_data, 64'h8877665544332211);
        check("dst_h5", 64'(output_hash_vec[5*HW +: HW]), 64'h05);
        chk_beat("dst", 8'hFF, 1'b1, 8'h00, 16'h0100, 1);
        check("dst_idle", 64'(output_valid), 64'd0);

        // back-to-back rows, one per cycle
        drive_row(16'h0100, 8'hFF, 64'h0706050403020100, 1'b0, 64'h0);
        @(posedge clk);
        @(negedge clk);
        drive_row(16'h0200, 8'hFF, 64'h0001020304050607, 1'b0, 64'h0);
        check("b2b_r1", 64'(input_ready), 64'd1);
        check("b2b_a0", 64'(output_addr_vec[0 +: AW]), 64'h0100);
        @(posedge clk);
        @(negedge clk);
        drive_row(16'h0300, 8'hFF, 64'h0706050403020100, 1'b0, 64'h0);
        check("b2b_r2", 64'(input_ready), 64'd1);
        check("b2b_b0", 64'(output_addr_vec[0 +: AW]), 64'h0207);
        check("b2b_bl", 64'(output_last), 64'd1);
        @(posedge clk);
        @(negedge clk);
        input_valid = 1'b0;
        check("b2b_c0", 64'(output_addr_vec[0 +: AW]), 64'h0300);
        check("b2b_cl", 64'(output_last), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle", 64'(output_valid), 64'd0);

        // full collision on bank 3
        load_row("col", 16'h0040, 8'hFF, 64'h3B332B231B130B03, 1'b0, 64'h0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("col%0d_irdy", k), 64'(input_ready),
                  64'(k == 7));
            check($sformatf("col%0d_h3", k),
                  64'(output_hash_vec[3*HW +: HW]), 64'(8 * k + 3));
            chk_beat($sformatf("col%0d", k), 8'h08, k == 7, 8'h00,
                     AW'(16'h0040 + k), 0);
        end
        check("col_idle", 64'(output_valid), 64'd0);

        // backpressure: 4 beats on banks 0/1, stall before beat 2
        load_row("bp", 16'h0A00, 8'hFF, 64'h0100010001000100, 1'b0, 64'h0);
        chk_beat("bp0", 8'h03, 1'b0, 8'h00, 16'h0A00, 1);
        chk_beat("bp1", 8'h03, 1'b0, 8'h00, 16'h0A02, 1);
        output_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check($sformatf("bps%0d_irdy", s), 64'(input_ready), 64'd0);
            chk_beat($sformatf("bps%0d", s), 8'h03, 1'b0, 8'h00,
                     16'h0A04, 1);
        end
        output_ready = 1'b1;
        chk_beat("bp2", 8'h03, 1'b0, 8'h00, 16'h0A04, 1);
        chk_beat("bp3", 8'h03, 1'b1, 8'h00, 16'h0A06, 1);
        check("bp_idle", 64'(output_valid), 64'd0);

        // partial row, positions 0 and 2 both on bank 4, delim set
        load_row("prt", 16'h0B00, 8'h05, 64'h0404040404040404, 1'b1, 64'h0);
        chk_beat("prt0", 8'h10, 1'b0, 8'h00, 16'h0B00, 0);
        chk_beat("prt1", 8'h10, 1'b1, 8'h10, 16'h0B02, 0);
        check("prt_idle", 64'(output_valid), 64'd0);

        // empty row
        load_row("emp", 16'h0C00, 8'h00, 64'h0706050403020100, 1'b1, 64'h0);
        chk_beat("emp", 8'h00, 1'b1, 8'h00, 16'h0C00, 0);
        check("emp_idle", 64'(output_valid), 64'd0);

        // address wrap
        load_row("wrp", 16'hFFFE, 8'hFF, 64'h0706050403020100, 1'b0, 64'h0);
        check("wrp_a1", 64'(output_addr_vec[1*AW +: AW]), 64'hFFFF);
        check("wrp_a2", 64'(output_addr_vec[2*AW +: AW]), 64'h0000);
        check("wrp_a7", 64'(output_addr_vec[7*AW +: AW]), 64'h0005);
        chk_beat("wrp", 8'hFF, 1'b1, 8'h00, 16'hFFFE, 1);

        // reset mid-row after two beats
        load_row("rsr", 16'h0D00, 8'hFF, 64'h0100010001000100, 1'b1,
                 64'hDEADBEEFCAFEF00D);
        chk_beat("rsr0", 8'h03, 1'b0, 8'h00, 16'h0D00, 1);
        chk_beat("rsr1", 8'h03, 1'b0, 8'h00, 16'h0D02, 1);
        rst_n = 1'b0;
        #1;
        check("rsr_vld", 64'(output_valid), 64'd0);
        check("rsr_mask", 64'(output_mask), 64'd0);
        check("rsr_irdy", 64'(input_ready), 64'd1);
        check("rsr_data", output_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rsr_rel_vld", 64'(output_valid), 64'd0);
        load_row("rsn", 16'h0500, 8'hFF, 64'h0706050403020100, 1'b0, 64'h0);
        chk_beat("rsn", 8'hFF, 1'b1, 8'h00, 16'h0500, 1);
        check("rsn_idle", 64'(output_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
